scoreboarded_register_file: RTL
===============================

# scoreboarded_register_file

Parametrised successor to the processor's 8 x 16-bit register file. It keeps two combinational read ports and one synchronous write port, and adds four things: configurable width and depth, an optional hardwired-zero register 0, write-to-read bypass, and a per-register busy scoreboard. The scoreboard tracks destinations reserved by multi-cycle producers (loads, multiply) and raises a stall to the decode stage until the matching writeback lands. It sits between decode (read/reserve) and writeback (write) in the pipeline.

## Interface
- DATA_WIDTH, 16, register and bus width
- ADDR_WIDTH, 3, register index width; NUM_REGS = 2**ADDR_WIDTH
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and cannot be reserved
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports

- clock  in  1  rising-edge clock, the only clock
- reset_n  in  1  asynchronous, active-low reset
- RA  in  ADDR_WIDTH  read port A index
- RB  in  ADDR_WIDTH  read port B index
- RW  in  ADDR_WIDTH  write index
- sig_enable_write  in  1  write strobe, sampled on rising clock
- BusW  in  DATA_WIDTH  write data
- RD  in  ADDR_WIDTH  index to reserve for a pending multi-cycle producer
- sig_reserve  in  1  reservation request
- BusA  out  DATA_WIDTH  read data A (combinational)
- BusB  out  DATA_WIDTH  read data B (combinational)
- sig_busy_A  out  1  register RA has an outstanding reservation
- sig_busy_B  out  1  register RB has an outstanding reservation
- sig_stall  out  1  decode must hold; a reservation this cycle is refused
- pending_count  out  ADDR_WIDTH+1  number of set busy bits (registered)

## Operation
- Storage is NUM_REGS x DATA_WIDTH, plus a NUM_REGS-bit busy vector.
- **Write.** On a rising clock with sig_enable_write=1, regs[RW] <= BusW and busy[RW] <= 0. If ZERO_REG=1 and RW=0, the write is dropped.
- **Read.** BusA = regs[RA], with these overrides:
  - 0 if ZERO_REG=1 and RA=0;
  - BusW if BYPASS=1, sig_enable_write=1, RW=RA, and RW is not the zero register.
  - BusB follows the same rules using RB.
- **Busy.**
  - sig_busy_A = busy[RA], masked to 0 when the bypass condition for A holds (the write completes the reservation this cycle). sig_busy_B is formed the same way.
  - With BYPASS=0, busy is not masked and the write data is not forwarded.
- **Stall.** sig_stall = sig_busy_A | sig_busy_B | (sig_reserve & busy[RD] & no clearing write to RD this cycle). The last term covers WAW.
- **Reserve.** On a rising clock with sig_reserve=1 and sig_stall=0, busy[RD] <= 1. The request is ignored when ZERO_REG=1 and RD=0, and ignored whenever sig_stall=1.
- **Simultaneous write and reserve to the same index** (RW=RD, both accepted): the data is written and busy ends at 1, because the reservation belongs to a newer producer.
- **Write to a non-busy register:** legal, and busy stays 0 (single-cycle producers do not reserve).
- **pending_count:** registered popcount of the next-state busy vector, so it is valid on the cycle after each update.

## Timing
- **Reset** (reset_n=0, asynchronous, takes effect immediately):
  - all regs = 0, busy = 0, pending_count = 0;
  - so BusA = BusB = 0 (absent a bypass), sig_busy_A = sig_busy_B = 0, and sig_stall = 0 unless inputs request a busy RD (impossible while busy = 0).
- Reset asserted mid-operation clears all reservations; pending producers' later writes land normally with busy already 0.
- Reset release is sampled by the first rising clock with reset_n=1, and writes or reserves take effect from that edge.
- **Read latency:** 0 cycles (combinational from RA/RB, the array, and the bypass inputs).
- **Write latency:**
  - data is visible on a read port the same cycle if BYPASS=1;
  - otherwise it is visible after the clock edge.
- **Reserve latency:** busy is visible on sig_busy_* in the cycle after the accepting edge.
- Stall is combinational. Decode must hold RA/RB/RD/sig_reserve stable while sig_stall=1.
- All index inputs are full range; there are no out-of-range indices.

## Test plan
- **Reset:** hold reset_n=0 for 2 cycles with writes strobed.
  - Expect BusA=BusB=0, pending_count=0, sig_stall=0.
  - Write reg1=8 while reset_n=0 → reg1 still reads 0 after release.
- **Basic write/read:** write reg1=8, then reg2=16, then read RA=1, RB=2.
  - Expect BusA=8, BusB=16.
  - Overwrite reg2=32 → BusB=32 (same cycle with BYPASS=1).
  - Write reg2=64 with sig_enable_write=0 → BusB stays 32.
- **Zero register:** write reg0=0xFFFF and reserve RD=0.
  - Expect BusA(RA=0)=0, sig_busy_A=0, pending_count unchanged.
- **Scoreboard:** reserve RD=3.
  - Next cycle with RA=3: sig_busy_A=1, sig_stall=1, pending_count=1.
  - Write reg3=0x1234 → same cycle BusA=0x1234, sig_busy_A=0, sig_stall=0; next cycle pending_count=0.
- **WAW and collision:**
  - With busy[5]=1, reserve RD=5 → sig_stall=1 and busy unchanged.
  - Same cycle write RW=5 with reserve RD=5 → stall=0, reg5 written, busy[5] ends 1, pending_count=1.
- **Parameter sweep:** repeat the basic and scoreboard scenarios with DATA_WIDTH=32, ADDR_WIDTH=4, ZERO_REG=0, BYPASS=0.
  - reg0 is writable.
  - A same-cycle read returns the old value and sig_busy_A stays 1 until the edge after the write.

Source files
------------

// File: rtl/scoreboarded_register_file.sv
// Parametrised register file with two combinational read ports, one write port, optional
// hardwired zero register, write-to-read bypass and a per-register busy scoreboard.
module scoreboarded_register_file #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] RA,
  input  logic [ADDR_WIDTH-1:0] RB,
  input  logic [ADDR_WIDTH-1:0] RW,
  input  logic                  sig_enable_write,
  input  logic [DATA_WIDTH-1:0] BusW,
  input  logic [ADDR_WIDTH-1:0] RD,
  input  logic                  sig_reserve,
  output logic [DATA_WIDTH-1:0] BusA,
  output logic [DATA_WIDTH-1:0] BusB,
  output logic                  sig_busy_A,
  output logic                  sig_busy_B,
  output logic                  sig_stall,
  output logic [ADDR_WIDTH:0]   pending_count
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic [NumRegs-1:0]    busy_q, busy_d;
  logic [ADDR_WIDTH:0]   pending_q, pending_d;

  logic write_ok, byp_a, byp_b, zero_a, zero_b, clear_rd, reserve_ok;

  assign write_ok = sig_enable_write && !(ZERO_REG && (RW == '0));
  assign zero_a   = ZERO_REG && (RA == '0);
  assign zero_b   = ZERO_REG && (RB == '0);
  assign byp_a    = BYPASS && write_ok && (RW == RA);
  assign byp_b    = BYPASS && write_ok && (RW == RB);
  // A write to RD clears its reservation at this edge, so a WAW reserve need not wait.
  assign clear_rd = write_ok && (RW == RD);

  always_comb begin
    BusA = regs_q[RA];
    if (zero_a) BusA = '0;
    else if (byp_a) BusA = BusW;
    BusB = regs_q[RB];
    if (zero_b) BusB = '0;
    else if (byp_b) BusB = BusW;
  end

  assign sig_busy_A = busy_q[RA] & ~byp_a;
  assign sig_busy_B = busy_q[RB] & ~byp_b;
  assign sig_stall  = sig_busy_A | sig_busy_B | (sig_reserve & busy_q[RD] & ~clear_rd);
  assign reserve_ok = sig_reserve && !sig_stall && !(ZERO_REG && (RD == '0));

  // Reserve is applied after the write clear so a same-index collision ends busy.
  always_comb begin
    busy_d = busy_q;
    if (write_ok)   busy_d[RW] = 1'b0;
    if (reserve_ok) busy_d[RD] = 1'b1;
    pending_d = '0;
    for (int i = 0; i < NumRegs; i++) begin
      pending_d = pending_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      if (write_ok) regs_q[RW] <= BusW;
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  assign pending_count = pending_q;

endmodule
